// File: rtl/inv_mixcolumn_serial.sv
// Inverse column mixing over GF(2^4) for the nibble cipher, one state row per cycle.
// The mixing matrix is involutory, so the forward coefficients are reused unchanged.
module inv_mixcolumn_serial #(
    parameter logic [3:0] POLY = 4'h3
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:3][0:3][3:0]   st_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:3][0:3][3:0]   inv_state,
    output logic                   inv_done,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    // Row-major: [0][0] is the most significant nibble.
    localparam logic [0:3][0:3][3:0] MIX = 64'hD941_9D14_41D9_149D;

    state_e                 state_q, state_d;
    logic [1:0]             row_q, row_d;
    logic [0:3][0:3][3:0]   s_q, s_d;
    logic [0:3][0:3][3:0]   inv_q, inv_d;
    logic                   done_q, done_d;

    logic [0:3][3:0]        row_in;
    logic [0:3][3:0]        row_out;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ POLY) : {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

    // Only the selected row feeds the four multiplier columns.
    assign row_in = s_q[row_q];

    always_comb begin
        row_out = '0;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                row_out[k] = row_out[k] ^ gf_mul(MIX[l][k], row_in[l]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        s_d     = s_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = st_in;
                    row_d   = 2'd0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                inv_d[row_q] = row_out;
                row_d        = row_q + 2'd1;
                if (row_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            row_q   <= 2'd0;
            s_q     <= '0;
            inv_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            s_q     <= s_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign inv_done  = done_q;
    assign inv_state = inv_q;

endmodule

// File: tb/tb_inv_mixcolumn_serial.sv
// Directed and round-trip bench for inv_mixcolumn_serial.
module tb_inv_mixcolumn_serial;

    typedef logic [0:3][0:3][3:0] state_t;

    localparam state_t MM = 64'hD941_9D14_41D9_149D;

    logic   clock = 1'b0;
    logic   rst;
    logic   in_valid;
    logic   in_ready;
    state_t st_in;
    logic   out_valid;
    logic   out_ready;
    state_t inv_state;
    logic   inv_done;
    logic   busy;

    int n_checks = 0;
    int n_pass   = 0;

    inv_mixcolumn_serial #(.POLY(4'h3)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .st_in     (st_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inv_state (inv_state),
        .inv_done  (inv_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Carry-less product followed by reduction modulo x^4+x+1.
    function automatic logic [3:0] gf_ref(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'd0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic state_t mix_ref(input state_t x);
        state_t y;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < 4; l++)
                    y[r][k] = y[r][k] ^ gf_ref(MM[l][k], x[r][l]);
        return y;
    endfunction

    // Offers x, scrambles st_in after acceptance, returns at the first out_valid sample.
    task automatic run_block(input state_t x, output state_t y, output int lat);
        int w;
        in_valid = 1'b1;
        st_in    = x;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        st_in    = ~x;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        y = inv_state;
    endtask

    state_t res, res2, rnd, held;
    state_t bb_in  [3];
    state_t bb_out [3];
    int     bb_acc [3];
    int     lat, na, no;
    logic   acc;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        st_in     = '0;
        tick();
        tick();
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_inv_done",  64'(inv_done),  64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        check("reset_inv_state", inv_state,      64'd0);
        rst = 1'b1;
        tick();

        // Abort in the middle of COMPUTE after row 0 has been written.
        in_valid = 1'b1;
        st_in    = 64'h1000_0000_0000_0000;
        tick();
        in_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_inv_state", inv_state,      64'd0);
        for (int i = 0; i < 6; i++) begin
            check("abort_quiet", {62'd0, out_valid, inv_done}, 64'd0);
            tick();
        end

        // Unit row with out_ready held high in advance.
        out_ready = 1'b1;
        run_block(64'h1000_0000_0000_0000, res, lat);
        check("unit_latency", 64'(lat), 64'd4);
        check("unit_result",  res,      64'hD941_0000_0000_0000);
        check("unit_in_ready_done", 64'(in_ready), 64'd0);
        tick();
        check("unit_done_pulse", 64'(inv_done),  64'd1);
        check("unit_ready_back", 64'(in_ready),  64'd1);
        check("unit_valid_drop", 64'(out_valid), 64'd0);
        tick();
        check("unit_done_single", 64'(inv_done), 64'd0);

        // Reduction and involution round trip.
        run_block(64'h8000_0100_1111_0000, res, lat);
        check("reduce_result", res, 64'h2468_9D14_1111_0000);
        tick();
        run_block(res, res2, lat);
        check("roundtrip_result", res2, 64'h8000_0100_1111_0000);
        tick();

        // Backpressure: output must hold, new offers ignored.
        out_ready = 1'b0;
        run_block(64'h0123_4567_89AB_CDEF, held, lat);
        check("bp_model", held, mix_ref(64'h0123_4567_89AB_CDEF));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            st_in    = {$urandom, $urandom};
            tick();
            check("bp_stable",   inv_state,        held);
            check("bp_in_ready", 64'(in_ready),    64'd0);
            check("bp_valid",    64'(out_valid),   64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_done_pulse",  64'(inv_done),  64'd1);
        check("bp_ready_back",  64'(in_ready),  64'd1);
        check("bp_retained",    inv_state,      held);
        tick();

        // Back-to-back with in_valid and out_ready held high.
        bb_in[0] = 64'hFEDC_BA98_7654_3210;
        bb_in[1] = 64'h0F0F_F0F0_1234_8421;
        bb_in[2] = 64'h5A5A_A5A5_3C3C_C3C3;
        na = 0;
        no = 0;
        in_valid = 1'b1;
        st_in    = bb_in[0];
        for (int c = 0; c < 60 && no < 3; c++) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                bb_out[no] = inv_state;
                no++;
            end
            if (acc) begin
                bb_acc[na] = c;
                na++;
            end
            tick();
            if (acc) begin
                if (na < 3) st_in = bb_in[na];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", 64'(na), 64'd3);
        check("b2b_outputs", 64'(no), 64'd3);
        if (na == 3) begin
            check("b2b_gap01", 64'(bb_acc[1] - bb_acc[0]), 64'd6);
            check("b2b_gap12", 64'(bb_acc[2] - bb_acc[1]), 64'd6);
        end
        for (int i = 0; i < no; i++) check("b2b_order", bb_out[i], mix_ref(bb_in[i]));
        tick();
        tick();

        // Random involution: f(f(x)) == x.
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom};
            run_block(rnd, res, lat);
            tick();
            check("rand_model", res, mix_ref(rnd));
            run_block(res, res2, lat);
            tick();
            check("rand_involution", res2, rnd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_mixcolumn_serial.md
Name: inv_mixcolumn_serial

Overview:
- Decrypt-side column mixing for the 4-bit-nibble cipher datapath over GF(2^4), polynomial x^4+x+1.
- Takes a 4x4 nibble state from the inverse-round controller through a valid/ready handshake and processes one state row per cycle, so only 4 GF multiplier columns are instantiated.
- Holds the result until the consumer accepts it.
- The mixing matrix M = [13,9,4,1; 9,13,1,4; 4,1,13,9; 1,4,9,13] is involutory over this field (M·M = I), so the inverse uses the same coefficients.

Parameters:
- POLY, 4'h3, low four bits of the reduction polynomial (x^4 = x+1). Must be 4'h3 for the cipher; exposed for bench use only.

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- in_valid  input  1  st_in is valid
- in_ready  output  1  block can accept a state
- st_in  input  [3:0] x [0:3][0:3]  state to un-mix, indexed [row][col]
- out_valid  output  1  inv_state is valid
- out_ready  input  1  consumer accepts inv_state
- inv_state  output  [3:0] x [0:3][0:3]  un-mixed state
- inv_done  output  1  one-cycle pulse on the cycle the output handshake completes
- busy  output  1  high in COMPUTE and DONE

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low on rst, sampled on the rising edge of clock.
  - Reset state: IDLE, in_ready=1, out_valid=0, inv_done=0, busy=0, row counter=0, inv_state all 4'h0, captured state all 4'h0.
  - Reset asserted in any state aborts the operation; no partial result is ever flagged valid.
- GF multiply gf(a,b):
  - Shift-and-add over the 4 bits of b.
  - When bit 3 of the shifted operand is set before a shift, the shifted value is ((a<<1)&4'hF)^POLY.
  - Result is always 4 bits.
  - Required values: gf(8,2)=3, gf(8,13)=2, gf(8,9)=4, gf(8,4)=6.
- Row function: inv_state[r][k] = XOR over l=0..3 of gf(M[l][k], S[r][l]), where S is the captured state.
- FSM IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture st_in into S, row counter=0, go to COMPUTE.
- FSM COMPUTE:
  - in_ready=0.
  - Each edge writes inv_state row [counter] and increments the counter.
  - After row 3 is written: counter wraps to 0, go to DONE, out_valid=1.
  - Latency: out_valid is visible exactly 4 clocks after the accepting edge.
- FSM DONE:
  - out_valid=1; inv_state is stable and st_in is ignored.
  - On out_ready: out_valid=0 and inv_done=1 for that one following cycle, return to IDLE.
  - in_ready returns to 1 the cycle after the handshake. There is no same-cycle accept of a new block: throughput is one state per 6 cycles minimum.
  - out_ready held high in advance completes the handshake on the first DONE cycle.
- in_valid while busy: ignored; the source must hold in_valid until in_ready.
- st_in changing after acceptance must not affect the result.
- inv_state retains its last value after the handshake until rows are overwritten by the next block.

Test Plan:
- Reset mid-COMPUTE: accept any state, drop rst for 1 cycle at cycle 2 -> IDLE, out_valid=0, inv_state=0, no inv_done pulse.
- Unit row: st_in row0=[1,0,0,0], other rows 0, out_ready=1 -> inv_state row0=[13,9,4,1], rows1-3=0, out_valid high 4 clocks after accept, inv_done single pulse.
- Reduction check: row0=[8,0,0,0], row1=[0,1,0,0], row2=[1,1,1,1], row3=[0,0,0,0] -> row0=[2,4,6,8], row1=[9,13,1,4], row2=[1,1,1,1], row3=[0,0,0,0].
- Involution round-trip: feed result of the reduction check back in -> original rows [8,0,0,0],[0,1,0,0],[1,1,1,1],[0,0,0,0]. Repeat with 200 random states: f(f(x))==x.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing st_in -> inv_state stable, in_ready=0, no new capture. Release -> inv_done pulse, in_ready=1 next cycle.
- Back-to-back: in_valid and out_ready held high, 3 states -> each accepted 6 cycles apart, outputs in order, no drops.
